// File: rtl/mem_block_mover_if.sv
// Command/status handshake plus single-port data memory bus for mem_block_mover.
// The master modport is the mover itself; slave is the sequencer/memory side.
interface mem_block_mover_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 5
);
    logic                 start;
    logic                 op;
    logic [ADDR_SIZE-1:0] src_addr;
    logic [ADDR_SIZE-1:0] dst_addr;
    logic [ADDR_SIZE:0]   len;
    logic [DATA_SIZE-1:0] fill_data;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [DATA_SIZE-1:0] checksum;
    logic                 mem_w;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        input  start, op, src_addr, dst_addr, len, fill_data, mem_rdata,
        output ready, busy, done, checksum, mem_w, mem_addr, mem_wdata
    );

    modport slave (
        output start, op, src_addr, dst_addr, len, fill_data, mem_rdata,
        input  ready, busy, done, checksum, mem_w, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block COPY/FILL engine owning the data memory port while busy.
// Reports completion with a done pulse and a modular checksum of written words.
module mem_block_mover #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 5
) (
    input  logic              clk,
    input  logic              rst,
    mem_block_mover_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    typedef enum logic {OP_COPY, OP_FILL} op_t;

    state_t               r_state;
    op_t                  r_op;
    logic [ADDR_SIZE-1:0] r_src;
    logic [ADDR_SIZE-1:0] r_dst;
    logic [ADDR_SIZE:0]   r_cnt;
    logic [DATA_SIZE-1:0] r_fill;
    logic [DATA_SIZE-1:0] r_hold;
    logic [DATA_SIZE-1:0] r_checksum;
    logic                 r_done;

    logic                 w_w;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [DATA_SIZE-1:0] w_wdata;

    always_comb begin
        w_w     = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            RD: w_addr = r_src;
            WR: begin
                w_w     = 1'b1;
                w_addr  = r_dst;
                w_wdata = (r_op == OP_FILL) ? r_fill : r_hold;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_COPY;
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_fill     <= '0;
            r_hold     <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op       <= op_t'(bus.op);
                        r_src      <= bus.src_addr;
                        r_dst      <= bus.dst_addr;
                        r_cnt      <= bus.len;
                        r_fill     <= bus.fill_data;
                        r_checksum <= '0;
                        // A zero-length command completes without touching memory
                        if (bus.len == '0)
                            r_done <= 1'b1;
                        else
                            r_state <= bus.op ? WR : RD;
                    end
                end
                RD: begin
                    r_hold  <= bus.mem_rdata;
                    r_state <= WR;
                end
                WR: begin
                    r_checksum <= r_checksum + w_wdata;
                    r_src      <= r_src + 1'b1;
                    r_dst      <= r_dst + 1'b1;
                    r_cnt      <= r_cnt - 1'b1;
                    if (r_cnt == (ADDR_SIZE+1)'(1)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= (r_op == OP_FILL) ? WR : RD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.checksum  = r_checksum;
    assign bus.mem_w     = w_w;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover: behavioural memory, array-level
// reference model, directed test-plan scenarios and randomized commands.
module tb_mem_block_mover;
    localparam int D = 8;
    localparam int A = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    mem_block_mover_if #(.DATA_SIZE(D), .ADDR_SIZE(A)) bus ();
    mem_block_mover #(.DATA_SIZE(D), .ADDR_SIZE(A)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // data memory: combinational read, write on posedge; bulk preload port for the bench
    logic [D-1:0] mem     [DEPTH];
    logic [D-1:0] pre_img [DEPTH];
    logic [D-1:0] ref_mem [DEPTH];
    logic         pre_en = 1'b0;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pre_img[i];
        end else if (bus.mem_w) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int           done_cyc, busy_cyc, wr_cnt, done_cnt, rb_err;
    logic [A-1:0] wa_q[$];
    logic [D-1:0] wd_q[$];
    logic [D-1:0] exp_sum;
    int           exp_done, exp_busy, exp_len;

    task automatic preload(input bit rnd);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            pre_img[i] = rnd ? D'($urandom) : D'(i);
            ref_mem[i] = pre_img[i];
        end
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // reference: word-by-word ascending transfer on the model array
    task automatic model_cmd(input bit op, input int src, input int dst, input int len,
                             input logic [D-1:0] fill);
        logic [D-1:0] v;
        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            v = op ? fill : ref_mem[(src + i) % DEPTH];
            ref_mem[(dst + i) % DEPTH] = v;
            exp_sum = exp_sum + v;
        end
        exp_len  = len;
        exp_done = (len == 0) ? 1 : (op ? len + 1 : 2 * len + 1);
        exp_busy = op ? len : 2 * len;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic observe();
        if (bus.mem_w) begin
            wr_cnt++;
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
        if (bus.busy) busy_cyc++;
        if (bus.done) done_cnt++;
        if (bus.busy !== ~bus.ready) rb_err++;
    endtask

    task automatic clear_obs();
        wa_q.delete(); wd_q.delete();
        done_cyc = -1; busy_cyc = 0; wr_cnt = 0; done_cnt = 0; rb_err = 0;
    endtask

    task automatic drive_cmd(input bit op, input int src, input int dst, input int len,
                             input logic [D-1:0] fill);
        bus.start = 1'b1; bus.op = op;
        bus.src_addr = A'(src); bus.dst_addr = A'(dst);
        bus.len = (A+1)'(len); bus.fill_data = fill;
    endtask

    // issues one command, records cycle of done (relative to accept edge), writes, busy cycles
    task automatic run_cmd(input bit op, input int src, input int dst, input int len,
                           input logic [D-1:0] fill, input bit hold_second);
        clear_obs();
        @(negedge clk);
        drive_cmd(op, src, dst, len, fill);
        @(negedge clk);
        if (hold_second) begin
            bus.dst_addr  = A'(dst + 16);
            bus.fill_data = ~fill;
        end else begin
            bus.start = 1'b0;
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            observe();
            if (bus.done) begin
                done_cyc  = cyc;
                bus.start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            observe();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.len = '0; bus.fill_data = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.ready, bus.busy, bus.done, bus.mem_w} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1000", {bus.ready, bus.busy, bus.done, bus.mem_w});
        end
        vectors++;
        if ({bus.checksum, bus.mem_addr, bus.mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", bus.checksum, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_copy();
        preload(1'b0);
        model_cmd(1'b0, 0, 16, 4, '0);
        run_cmd(1'b0, 0, 16, 4, '0, 1'b0);
        vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL copy_done_cycle: got %0d expected 9", done_cyc); end
        vectors++; if (wr_cnt !== 4) begin miscompares++; $display("FAIL copy_writes: got %0d expected 4", wr_cnt); end
        vectors++; if (busy_cyc !== 8) begin miscompares++; $display("FAIL copy_busy: got %0d expected 8", busy_cyc); end
        vectors++; if (bus.checksum !== 8'h06) begin miscompares++; $display("FAIL copy_checksum: got %h expected 06", bus.checksum); end
        vectors++; if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h00010203) begin
            miscompares++; $display("FAIL copy_data: got %h%h%h%h expected 00010203", mem[16], mem[17], mem[18], mem[19]); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL copy_mem: got %0d bad words expected 0", mem_diffs()); end
        vectors++; if (rb_err !== 0) begin miscompares++; $display("FAIL copy_ready_busy: got %0d violations expected 0", rb_err); end
    endtask

    task automatic test_fill_wrap();
        logic [4*A-1:0] got_a;
        model_cmd(1'b1, 0, 30, 4, 8'hA5);
        run_cmd(1'b1, 0, 30, 4, 8'hA5, 1'b0);
        got_a = '1;
        if (wa_q.size() == 4) got_a = {wa_q[0], wa_q[1], wa_q[2], wa_q[3]};
        vectors++; if (got_a !== {5'd30, 5'd31, 5'd0, 5'd1}) begin
            miscompares++; $display("FAIL fill_wrap_addrs: got %h (n=%0d) expected 30,31,0,1", got_a, wa_q.size()); end
        vectors++; if (busy_cyc !== 4) begin miscompares++; $display("FAIL fill_wrap_busy: got %0d expected 4", busy_cyc); end
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL fill_wrap_done_cycle: got %0d expected 5", done_cyc); end
        vectors++; if (bus.checksum !== 8'h94) begin miscompares++; $display("FAIL fill_wrap_checksum: got %h expected 94", bus.checksum); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL fill_wrap_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_overlap();
        preload(1'b0);
        model_cmd(1'b0, 0, 1, 3, '0);
        run_cmd(1'b0, 0, 1, 3, '0, 1'b0);
        vectors++; if ({mem[1], mem[2], mem[3]} !== 24'h000000) begin
            miscompares++; $display("FAIL overlap_data: got %h%h%h expected 000000", mem[1], mem[2], mem[3]); end
        vectors++; if (bus.checksum !== 8'h00) begin miscompares++; $display("FAIL overlap_checksum: got %h expected 00", bus.checksum); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL overlap_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_len0();
        model_cmd(1'b1, 0, 12, 1, 8'h33);
        run_cmd(1'b1, 0, 12, 1, 8'h33, 1'b0);
        vectors++; if (bus.checksum !== 8'h33) begin miscompares++; $display("FAIL len0_pre_checksum: got %h expected 33", bus.checksum); end
        run_cmd(1'b0, 4, 9, 0, '0, 1'b0);
        vectors++; if (busy_cyc !== 0) begin miscompares++; $display("FAIL len0_busy: got %0d expected 0", busy_cyc); end
        vectors++; if (wr_cnt !== 0) begin miscompares++; $display("FAIL len0_writes: got %0d expected 0", wr_cnt); end
        vectors++; if (done_cyc !== 1) begin miscompares++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
        vectors++; if (bus.checksum !== 8'h00) begin miscompares++; $display("FAIL len0_checksum: got %h expected 00", bus.checksum); end
    endtask

    task automatic test_busy_ignore();
        model_cmd(1'b1, 0, 8, 5, 8'h5A);
        run_cmd(1'b1, 0, 8, 5, 8'h5A, 1'b1);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        vectors++; if (wr_cnt !== 5) begin miscompares++; $display("FAIL ignore_writes: got %0d expected 5", wr_cnt); end
        vectors++; if (done_cyc !== 6) begin miscompares++; $display("FAIL ignore_done_cycle: got %0d expected 6", done_cyc); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL ignore_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_rst_mid();
        preload(1'b1);
        clear_obs();
        @(negedge clk);
        drive_cmd(1'b0, 0, 20, 8, '0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            observe();
            if (cyc == 3) rst = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if ({bus.ready, bus.mem_w, bus.done, bus.checksum} !== {3'b100, 8'h00}) begin
            miscompares++; $display("FAIL rst_mid_state: got r=%b w=%b d=%b cs=%h expected r=1 w=0 d=0 cs=00",
                                    bus.ready, bus.mem_w, bus.done, bus.checksum); end
        rst = 1'b0;
        vectors++;
        if (wr_cnt > 1 || (wr_cnt == 1 && wa_q[0] !== 5'd20)) begin
            miscompares++; $display("FAIL rst_mid_writes: got %0d writes expected at most one at 20", wr_cnt); end
        if (wr_cnt == 1) ref_mem[20] = ref_mem[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            observe();
        end
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL rst_mid_mem: got %0d bad words expected 0", mem_diffs()); end
        model_cmd(1'b1, 0, 2, 2, 8'h7E);
        run_cmd(1'b1, 0, 2, 2, 8'h7E, 1'b0);
        vectors++; if (done_cyc !== 3) begin miscompares++; $display("FAIL rst_mid_refill_done: got %0d expected 3", done_cyc); end
        vectors++; if (bus.checksum !== 8'hFC) begin miscompares++; $display("FAIL rst_mid_refill_checksum: got %h expected fc", bus.checksum); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL rst_mid_refill_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_full_fill();
        model_cmd(1'b1, 0, 5, 32, 8'h01);
        run_cmd(1'b1, 0, 5, 32, 8'h01, 1'b0);
        vectors++; if (done_cyc !== 33) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected 33", done_cyc); end
        vectors++; if (wr_cnt !== 32) begin miscompares++; $display("FAIL full_writes: got %0d expected 32", wr_cnt); end
        vectors++; if (bus.checksum !== 8'h20) begin miscompares++; $display("FAIL full_checksum: got %h expected 20", bus.checksum); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL full_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_back_to_back();
        int cyc2;
        model_cmd(1'b1, 0, 0, 2, 8'h11);
        model_cmd(1'b1, 0, 10, 3, 8'h22);
        clear_obs();
        @(negedge clk);
        drive_cmd(1'b1, 0, 0, 2, 8'h11);
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 50 && !bus.done; cyc++) @(negedge clk);
        vectors++; if (bus.ready !== 1'b1 || bus.done !== 1'b1) begin
            miscompares++; $display("FAIL b2b_done_ready: got done=%b ready=%b expected 1/1", bus.done, bus.ready); end
        drive_cmd(1'b1, 0, 10, 3, 8'h22);
        @(negedge clk);
        bus.start = 1'b0;
        cyc2 = -1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (bus.done) begin cyc2 = cyc; break; end
            @(negedge clk);
        end
        vectors++; if (cyc2 !== 4) begin miscompares++; $display("FAIL b2b_done_cycle: got %0d expected 4", cyc2); end
        vectors++; if (bus.checksum !== exp_sum) begin miscompares++; $display("FAIL b2b_checksum: got %h expected %h", bus.checksum, exp_sum); end
        vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL b2b_mem: got %0d bad words expected 0", mem_diffs()); end
    endtask

    task automatic test_random();
        bit           op;
        int           src, dst, len;
        logic [D-1:0] fill;
        preload(1'b1);
        for (int n = 0; n < 16; n++) begin
            op   = 1'($urandom);
            src  = int'($urandom_range(0, DEPTH - 1));
            dst  = int'($urandom_range(0, DEPTH - 1));
            len  = (n % 5 == 4) ? 0 : int'($urandom_range(1, DEPTH));
            fill = D'($urandom);
            model_cmd(op, src, dst, len, fill);
            run_cmd(op, src, dst, len, fill, 1'b0);
            vectors++; if (done_cyc !== exp_done) begin miscompares++;
                $display("FAIL rand%0d_done_cycle: got %0d expected %0d", n, done_cyc, exp_done); end
            vectors++; if (busy_cyc !== exp_busy) begin miscompares++;
                $display("FAIL rand%0d_busy: got %0d expected %0d", n, busy_cyc, exp_busy); end
            vectors++; if (wr_cnt !== exp_len) begin miscompares++;
                $display("FAIL rand%0d_writes: got %0d expected %0d", n, wr_cnt, exp_len); end
            vectors++; if (bus.checksum !== exp_sum) begin miscompares++;
                $display("FAIL rand%0d_checksum: got %h expected %h", n, bus.checksum, exp_sum); end
            vectors++; if (mem_diffs() !== 0) begin miscompares++;
                $display("FAIL rand%0d_mem: got %0d bad words expected 0", n, mem_diffs()); end
            vectors++; if (rb_err !== 0) begin miscompares++;
                $display("FAIL rand%0d_ready_busy: got %0d violations expected 0", n, rb_err); end
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill_wrap();
        test_overlap();
        test_len0();
        test_busy_ignore();
        test_rst_mid();
        test_full_fill();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
